pipe_enq_arbiter: RTL

PIPE_ENQ_ARBITER -- requirements
Module: pipe_enq_arbiter

---
 rtl/pipe_enq_arbiter_pkg.sv | 36 +++
 rtl/pipe_enq_arbiter_fifo2w.sv | 69 ++++++
 rtl/pipe_enq_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipe_enq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_enq_arbiter_pkg
// Description : Shared constants, types and sizing helpers for the Echo pipe
//               blocks (message width, FIFO depth, pointer/count widths).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_enq_arbiter_pkg;

    // Default pipe message width in bits.
    localparam int c_pipe_width = 96;

    // Default pipe FIFO depth (power of two, at least 2).
    localparam int c_pipe_depth = 4;

    // Pointer width for a FIFO of the given depth (log2, never below 1 bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must hold every value 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width for the default depth.
    localparam int c_pipe_ptr_w = ptr_width(c_pipe_depth);

    // Identifies which requester currently holds priority.
    typedef enum logic {
        c_port0 = 1'b0,
        c_port1 = 1'b1
    } port_sel_e;

endpackage : pipe_enq_arbiter_pkg
`default_nettype wire

// File: rtl/pipe_enq_arbiter_fifo2w.sv
`default_nettype none
// ============================================================================
// Module      : l_pipe_fifo2w
// Description : DEPTH-entry FIFO with two write ports and one read port.
//               Write port A lands at the tail, write port B at the slot
//               after it, so port B is only meaningful together with port A.
//               The read port presents the head entry combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module l_pipe_fifo2w
    import pipe_enq_arbiter_pkg::*;
#(
    parameter int WIDTH = c_pipe_width,
    parameter int DEPTH = c_pipe_depth
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_a_en,
    input  logic [WIDTH-1:0]             i_wr_a_data,
    input  logic                         i_wr_b_en,
    input  logic [WIDTH-1:0]             i_wr_b_data,
    input  logic                         i_rd_en,
    output logic [WIDTH-1:0]             o_rd_data,
    output logic [cnt_width(DEPTH)-1:0]  o_count
);

    localparam int c_ptr_w = ptr_width(DEPTH);
    localparam int c_cnt_w = cnt_width(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;

    logic [c_ptr_w-1:0] w_tail_plus1;
    logic [1:0]         w_num_wr;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign w_tail_plus1 = r_tail + c_ptr_w'(1);
    assign w_num_wr     = {1'b0, i_wr_a_en} + {1'b0, i_wr_b_en};

    // Storage array: contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (i_wr_a_en) begin
            r_mem[r_tail] <= i_wr_a_data;
        end
        if (i_wr_b_en) begin
            r_mem[w_tail_plus1] <= i_wr_b_data;
        end
    end

    // Head/tail pointers and occupancy, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + c_ptr_w'(w_num_wr);
            r_head  <= r_head + c_ptr_w'(i_rd_en);
            r_count <= r_count + c_cnt_w'(w_num_wr) - c_cnt_w'(i_rd_en);
        end
    end

    assign o_rd_data = r_mem[r_head];
    assign o_count   = r_count;

endmodule : l_pipe_fifo2w
`default_nettype wire

// File: rtl/pipe_enq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_enq_arbiter
// Description : Merges two enqueue requesters into one downstream pipe via a
//               small FIFO. Ready is derived only from FIFO occupancy (never
//               from ENA). When exactly one slot is free, a toggling priority
//               bit decides which requester may take it; when both requesters
//               enqueue together the priority port's message goes first.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_enq_arbiter
    import pipe_enq_arbiter_pkg::*;
#(
    parameter int WIDTH = c_pipe_width,
    parameter int DEPTH = c_pipe_depth
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in0_enq__ENA,
    input  logic [WIDTH-1:0] in0_enq_v,
    output logic             in0_enq__RDY,
    input  logic             in1_enq__ENA,
    input  logic [WIDTH-1:0] in1_enq_v,
    output logic             in1_enq__RDY,
    output logic             out_enq__ENA,
    output logic [WIDTH-1:0] out_enq_v,
    input  logic             out_enq__RDY,
    output logic             err_proto
);

    localparam int c_cnt_w = cnt_width(DEPTH);

    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w-1:0] w_free;
    logic               w_free_one;
    logic               w_free_two;
    logic               w_out_ena;
    logic               w_rdy0;
    logic               w_rdy1;
    logic               w_acc0;
    logic               w_acc1;
    logic               w_both;
    logic               w_prio_acc;
    logic               w_proto_viol;
    logic               w_wr_a_en;
    logic               w_wr_b_en;
    logic [WIDTH-1:0]   w_wr_a_data;
    logic [WIDTH-1:0]   w_wr_b_data;
    logic [WIDTH-1:0]   w_head_data;

    port_sel_e          r_prio;
    logic               r_err_proto;

    // Downstream strobe: anything buffered and the sink can take it.
    assign w_out_ena = (w_count != '0) && out_enq__RDY;

    // Free slots this cycle, counting the slot released by a same-cycle dequeue.
    assign w_free     = c_cnt_w'(DEPTH) - w_count + c_cnt_w'(w_out_ena);
    assign w_free_one = (w_free == c_cnt_w'(1));
    assign w_free_two = (w_free >= c_cnt_w'(2));

    // Ready depends only on occupancy and priority; nRST forces both low
    // immediately, since an empty FIFO would otherwise report ready.
    assign w_rdy0 = nRST && (w_free_two || (w_free_one && (r_prio == c_port0)));
    assign w_rdy1 = nRST && (w_free_two || (w_free_one && (r_prio == c_port1)));

    assign w_acc0 = in0_enq__ENA && w_rdy0;
    assign w_acc1 = in1_enq__ENA && w_rdy1;
    assign w_both = w_acc0 && w_acc1;

    assign w_prio_acc   = (r_prio == c_port0) ? w_acc0 : w_acc1;
    assign w_proto_viol = (in0_enq__ENA && !w_rdy0) || (in1_enq__ENA && !w_rdy1);

    // Map accepted messages onto the FIFO write ports: priority port first.
    always_comb begin
        w_wr_a_en   = w_acc0 || w_acc1;
        w_wr_b_en   = w_both;
        w_wr_a_data = in0_enq_v;
        w_wr_b_data = in1_enq_v;
        if (w_both) begin
            if (r_prio == c_port1) begin
                w_wr_a_data = in1_enq_v;
                w_wr_b_data = in0_enq_v;
            end
        end else if (w_acc1) begin
            w_wr_a_data = in1_enq_v;
        end
    end

    // Priority rotates after the priority port is served, or when the single
    // free slot went unused by it, so the other port cannot be locked out.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_prio      <= c_port0;
            r_err_proto <= 1'b0;
        end else begin
            if (w_prio_acc || w_free_one) begin
                r_prio <= (r_prio == c_port0) ? c_port1 : c_port0;
            end
            if (w_proto_viol) begin
                r_err_proto <= 1'b1;
            end
        end
    end

    l_pipe_fifo2w #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (CLK),
        .rst_n       (nRST),
        .i_wr_a_en   (w_wr_a_en),
        .i_wr_a_data (w_wr_a_data),
        .i_wr_b_en   (w_wr_b_en),
        .i_wr_b_data (w_wr_b_data),
        .i_rd_en     (w_out_ena),
        .o_rd_data   (w_head_data),
        .o_count     (w_count)
    );

    assign in0_enq__RDY = w_rdy0;
    assign in1_enq__RDY = w_rdy1;
    assign out_enq__ENA = w_out_ena;
    assign out_enq_v    = w_head_data;
    assign err_proto    = r_err_proto;

endmodule : pipe_enq_arbiter
`default_nettype wire
